// File: rtl/memstage.sv
// LEGv8 memory-access stage: req/ack data-memory FSM, NZCV flags register,
// branch resolution and the registered MEM/WB outputs.
module memstage #(
    parameter int WORDSIZE    = 64,
    parameter int OPCODESIZE  = 11,
    parameter int REGADDRSIZE = 5,
    parameter int CTRLSIZE    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CTRLSIZE-1:0]    control,
    input  logic [OPCODESIZE-1:0]  opcode,
    input  logic [WORDSIZE-1:0]    branchpc,
    input  logic [WORDSIZE-1:0]    alures,
    input  logic [WORDSIZE-1:0]    movres,
    input  logic [WORDSIZE-1:0]    readreg2,
    input  logic [3:0]             flagstoset,
    input  logic [REGADDRSIZE-1:0] rd,
    output logic                   stall,
    output logic                   pcsrc,
    output logic [WORDSIZE-1:0]    branchtarget,
    output logic [3:0]             flags,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [WORDSIZE-1:0]    dmem_addr,
    output logic [WORDSIZE-1:0]    dmem_wdata,
    input  logic [WORDSIZE-1:0]    dmem_rdata,
    input  logic                   dmem_ack,
    output logic                   wb_regwrite,
    output logic [REGADDRSIZE-1:0] wb_rd,
    output logic [WORDSIZE-1:0]    wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [WORDSIZE-1:0] rdata_q;
    logic [WORDSIZE-1:0] wb_data_next;
    logic                memread, memwrite, regwrite, memtoreg;
    logic                condbranch, uncondbranch, setflags, movsel;
    logic                memop, cond_true, taken;
    logic [7:0]          op_hi;
    logic                unused_bits;

    assign memread      = control[0];
    assign memwrite     = control[1];
    assign regwrite     = control[2];
    assign memtoreg     = control[3];
    assign condbranch   = control[4];
    assign uncondbranch = control[5];
    assign setflags     = control[6];
    assign movsel       = control[7];
    assign op_hi        = opcode[OPCODESIZE-1 -: 8];
    assign unused_bits  = ^{opcode[OPCODESIZE-9:0], rd[REGADDRSIZE-1:4]};

    assign memop        = memread | memwrite;
    assign stall        = memop & (state != DONE);
    assign dmem_req     = (state == REQ);
    assign dmem_we      = memwrite;
    assign dmem_addr    = alures;
    assign dmem_wdata   = readreg2;
    assign branchtarget = branchpc;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next = state;
        unique case (state)
            IDLE:    if (memop) state_next = REQ;
            REQ:     if (dmem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Flags are N Z C V in bits 3..0; B.cond sees the value before this edge.
    always_comb begin
        cond_true = 1'b0;
        unique case (rd[3:0])
            4'h0: cond_true = flags[2];
            4'h1: cond_true = !flags[2];
            4'h2: cond_true = flags[1];
            4'h3: cond_true = !flags[1];
            4'h4: cond_true = flags[3];
            4'h5: cond_true = !flags[3];
            4'h6: cond_true = flags[0];
            4'h7: cond_true = !flags[0];
            4'h8: cond_true = flags[1] & !flags[2];
            4'h9: cond_true = !(flags[1] & !flags[2]);
            4'hA: cond_true = (flags[3] == flags[0]);
            4'hB: cond_true = (flags[3] != flags[0]);
            4'hC: cond_true = !flags[2] & (flags[3] == flags[0]);
            4'hD: cond_true = !(!flags[2] & (flags[3] == flags[0]));
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        taken = uncondbranch
              | (condbranch & (op_hi == 8'h54) & cond_true)
              | ((op_hi == 8'hB4) & (readreg2 == '0))
              | ((op_hi == 8'hB5) & (readreg2 != '0));
        pcsrc = taken & ~stall;
    end

    always_comb begin
        wb_data_next = alures;
        if (memtoreg)
            wb_data_next = rdata_q;
        else if (movsel)
            wb_data_next = movres;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
            flags   <= 4'b0000;
        end else begin
            state <= state_next;
            if (state == REQ && dmem_ack)
                rdata_q <= dmem_rdata;
            if (!stall && setflags)
                flags <= flagstoset;
        end
    end

    // A stalled edge pushes a bubble into MEM/WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else if (stall) begin
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else begin
            wb_regwrite <= regwrite;
            wb_rd       <= rd;
            wb_data     <= wb_data_next;
        end
    end

endmodule

// File: tb/tb_memstage.sv
// Directed bench for memstage: per-cycle checks of stall/req/pcsrc and a
// scoreboard of expected MEM/WB contents pushed before each edge.
module tb_memstage;

    localparam logic [7:0] C_MEMREAD = 8'h01, C_MEMWRITE = 8'h02, C_REGWRITE = 8'h04,
                           C_MEMTOREG = 8'h08, C_CONDBR = 8'h10, C_UNCONDBR = 8'h20,
                           C_SETFLAGS = 8'h40, C_MOVSEL = 8'h80;
    localparam logic [10:0] OP_ADD  = 11'b10001011000, OP_SUBS = 11'b11101011000,
                            OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000,
                            OP_MOVZ = 11'b11010010100, OP_BCOND = {8'h54, 3'b000},
                            OP_CBZ  = {8'hB4, 3'b000}, OP_CBNZ = {8'hB5, 3'b000};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  control;
    logic [10:0] opcode;
    logic [63:0] branchpc, alures, movres, readreg2;
    logic [3:0]  flagstoset;
    logic [4:0]  rd;
    logic        stall, pcsrc;
    logic [63:0] branchtarget;
    logic [3:0]  flags;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    wb_t         sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] model_rdata = '0;

    memstage dut (
        .clk(clk), .rst(rst), .control(control), .opcode(opcode),
        .branchpc(branchpc), .alures(alures), .movres(movres), .readreg2(readreg2),
        .flagstoset(flagstoset), .rd(rd), .stall(stall), .pcsrc(pcsrc),
        .branchtarget(branchtarget), .flags(flags), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] c, input logic [10:0] op, input logic [63:0] alu,
                          input logic [63:0] r2, input logic [4:0] dst);
        control    = c;
        opcode     = op;
        alures     = alu;
        readreg2   = r2;
        rd         = dst;
        movres     = '0;
        flagstoset = '0;
        branchpc   = '0;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick(input string tag, input logic e_stall, input logic e_req, input logic e_pcsrc);
        wb_t exp;
        @(negedge clk);
        check({tag, ".stall"}, stall, e_stall);
        check({tag, ".req"}, dmem_req, e_req);
        check({tag, ".pcsrc"}, pcsrc, e_pcsrc);
        if (e_stall) begin
            exp = '0;
        end else begin
            exp.regwrite = control[2];
            exp.rd       = rd;
            exp.data     = control[3] ? model_rdata : (control[7] ? movres : alures);
        end
        sb.push_back(exp);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        check({tag, ".wb_regwrite"}, wb_regwrite, exp.regwrite);
        check({tag, ".wb_rd"}, wb_rd, exp.rd);
        check({tag, ".wb_data"}, wb_data, exp.data);
    endtask

    initial begin
        rst = 1'b1;
        set_op(8'h00, 11'h000, '0, '0, '0);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        #2;
        check("reset.req", dmem_req, 0);
        check("reset.flags", flags, 0);
        check("reset.wb_regwrite", wb_regwrite, 0);
        check("reset.wb_data", wb_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD x3 = 0x2A
        set_op(C_REGWRITE, OP_ADD, 64'h2A, '0, 5'd3);
        tick("add", 0, 0, 0);

        // LDUR from 0x100; a stray ack in IDLE must be ignored, real ack in 3rd REQ cycle
        set_op(C_MEMREAD | C_REGWRITE | C_MEMTOREG, OP_LDUR, 64'h100, '0, 5'd5);
        dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
        tick("ldur.c0", 1, 0, 0);
        dmem_ack = 1'b0;
        tick("ldur.c1", 1, 1, 0);
        check("ldur.addr", dmem_addr, 64'h100);
        check("ldur.we", dmem_we, 0);
        tick("ldur.c2", 1, 1, 0);
        dmem_ack = 1'b1; dmem_rdata = 64'hDEAD;
        model_rdata = 64'hDEAD;
        tick("ldur.c3", 1, 1, 0);
        dmem_ack = 1'b0;
        tick("ldur.done", 0, 0, 0);

        // STUR of 0x55 to 0x200
        set_op(C_MEMWRITE, OP_STUR, 64'h200, 64'h55, 5'd0);
        tick("stur.c0", 1, 0, 0);
        check("stur.we", dmem_we, 1);
        check("stur.wdata", dmem_wdata, 64'h55);
        dmem_ack = 1'b1;
        tick("stur.c1", 1, 1, 0);
        dmem_ack = 1'b0;
        tick("stur.done", 0, 0, 0);

        // MOVZ x7 = 0x1234
        set_op(C_REGWRITE | C_MOVSEL, OP_MOVZ, 64'h99, '0, 5'd7);
        movres = 64'h1234;
        tick("movz", 0, 0, 0);

        // SUBS sets Z, then B.EQ taken
        set_op(C_REGWRITE | C_SETFLAGS, OP_SUBS, '0, '0, 5'd1);
        flagstoset = 4'b0100;
        tick("subs_z", 0, 0, 0);
        check("subs_z.flags", flags, 4'b0100);
        set_op(C_CONDBR, OP_BCOND, '0, '0, 5'd0);
        branchpc = 64'h40;
        #1;
        check("beq.target", branchtarget, 64'h40);
        tick("beq_taken", 0, 0, 1);

        // Clear flags, B.EQ not taken, B.GE taken (N==V)
        set_op(C_REGWRITE | C_SETFLAGS, OP_SUBS, '0, '0, 5'd1);
        flagstoset = 4'b0000;
        tick("subs_0", 0, 0, 0);
        check("subs_0.flags", flags, 4'b0000);
        set_op(C_CONDBR, OP_BCOND, '0, '0, 5'd0);
        branchpc = 64'h40;
        tick("beq_not", 0, 0, 0);
        set_op(C_CONDBR, OP_BCOND, '0, '0, 5'hA);
        branchpc = 64'h80;
        tick("bge_taken", 0, 0, 1);

        // Set all flags so the reset check below sees them cleared
        set_op(C_SETFLAGS, OP_SUBS, '0, '0, 5'd0);
        flagstoset = 4'b1111;
        tick("subs_f", 0, 0, 0);
        check("subs_f.flags", flags, 4'b1111);

        // CBNZ / CBZ with a zero operand
        set_op(C_CONDBR, OP_CBNZ, '0, '0, 5'd0);
        tick("cbnz_zero", 0, 0, 0);
        set_op(C_CONDBR, OP_CBZ, '0, '0, 5'd0);
        tick("cbz_zero", 0, 0, 1);

        // Put a nonzero value into MEM/WB, then reset in the 2nd REQ cycle of a load
        set_op(C_REGWRITE, OP_ADD, 64'h77, '0, 5'd9);
        tick("add2", 0, 0, 0);
        set_op(C_MEMREAD | C_REGWRITE | C_MEMTOREG, OP_LDUR, 64'h300, '0, 5'd6);
        tick("rld.c0", 1, 0, 0);
        tick("rld.c1", 1, 1, 0);
        rst = 1'b1;
        #1;
        check("rst.req", dmem_req, 0);
        check("rst.flags", flags, 0);
        check("rst.wb_regwrite", wb_regwrite, 0);
        check("rst.wb_rd", wb_rd, 0);
        check("rst.wb_data", wb_data, 0);
        dmem_ack = 1'b1; dmem_rdata = 64'hF00D;
        @(posedge clk);
        #1;
        check("rst.ack_req", dmem_req, 0);
        check("rst.ack_wb", wb_data, 0);
        rst = 1'b0;
        dmem_ack = 1'b0;
        tick("rld2.c0", 1, 0, 0);
        dmem_ack = 1'b1; dmem_rdata = 64'hBEEF;
        model_rdata = 64'hBEEF;
        tick("rld2.c1", 1, 1, 0);
        dmem_ack = 1'b0;
        tick("rld2.done", 0, 0, 0);

        set_op(8'h00, 11'h000, '0, '0, '0);
        tick("bubble", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memstage.md
# memstage

Memory-access stage of the pipelined LEGv8 core. It consumes the EX/MEM pipeline register outputs, performs LDUR/STUR through a req/ack data-memory port, and stalls upstream while an access is outstanding. It also owns the NZCV flags register, resolves B, B.cond, CBZ and CBNZ, and drives the registered MEM/WB outputs.

## Interface
- `WORDSIZE`, 64, data/address width
- `OPCODESIZE`, 11, opcode width
- `REGADDRSIZE`, 5, register index width
- `CTRLSIZE`, 8, control bus width. Bit 0 memread, 1 memwrite, 2 regwrite, 3 memtoreg, 4 condbranch, 5 uncondbranch, 6 setflags, 7 movsel
- Reset policy (already decided): one clock; reset is asynchronous and active-high.
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous active-high reset
- `control` in CTRLSIZE, EX/MEM control; all-zero means bubble
- `opcode` in OPCODESIZE, EX/MEM opcode
- `branchpc` in WORDSIZE, precomputed branch target
- `alures` in WORDSIZE, ALU result / memory address
- `movres` in WORDSIZE, MOVZ/MOVK result
- `readreg2` in WORDSIZE, store data / CBZ operand
- `flagstoset` in 4, NZCV from ALU, [3]=N [2]=Z [1]=C [0]=V
- `rd` in REGADDRSIZE, destination; bits [3:0] are the cond code for B.cond
- `stall` out 1, upstream registers hold while high
- `pcsrc` out 1, taken branch; redirect fetch to `branchtarget` and flush younger stages
- `branchtarget` out WORDSIZE, equals `branchpc`
- `flags` out 4, current NZCV register
- `dmem_req`, `dmem_we` out 1, memory request and write enable
- `dmem_addr`, `dmem_wdata` out WORDSIZE, memory address and write data
- `dmem_rdata` in WORDSIZE, read data, valid with ack
- `dmem_ack` in 1, access complete
- `wb_regwrite` out 1, MEM/WB write enable
- `wb_rd` out REGADDRSIZE, MEM/WB destination
- `wb_data` out WORDSIZE, MEM/WB write data

## Operation
- An access is pending when `memop = memread | memwrite`.
- FSM states:
  - IDLE: if `memop`, go to REQ.
  - REQ: `dmem_req=1`; on `dmem_ack`, capture `dmem_rdata` into `rdata_q` and go to DONE.
  - DONE: unconditionally return to IDLE.
- `stall = memop & (state != DONE)`. This is combinational. Non-memory instructions never stall.
- `dmem_addr = alures` and `dmem_wdata = readreg2`. `dmem_we = memwrite`. Upstream holds all of these stable during REQ.
- An instruction retires in a cycle where `stall=0`.
  - On the retire edge, MEM/WB loads `wb_regwrite=regwrite`, `wb_rd=rd`, and `wb_data` from one of three sources:
    - `rdata_q` if memtoreg
    - else `movres` if movsel
    - else `alures`
  - On every stalled edge, MEM/WB loads a bubble: `wb_regwrite=0`, `wb_rd=0`, `wb_data=0`.
- Flags load `flagstoset` on the retire edge when setflags=1. Otherwise they hold.
- Branch taken:
  - uncondbranch
  - or condbranch with `opcode[10:3]=8'h54` (B.cond) and cond true
  - or `opcode[10:3]=8'hB4` (CBZ) and `readreg2==0`
  - or `opcode[10:3]=8'hB5` (CBNZ) and `readreg2!=0`
- `pcsrc = taken & ~stall`.
- B.cond evaluates against the current flags register, i.e. before any update on this edge.
- Cond codes, from `rd[3:0]`:
  - 0 EQ Z, 1 NE !Z
  - 2 HS C, 3 LO !C
  - 4 MI N, 5 PL !N
  - 6 VS V, 7 VC !V
  - 8 HI C&!Z, 9 LS !(C&!Z)
  - A GE N==V, B LT N!=V
  - C GT !Z&(N==V), D LE the inverse of GT
  - E and F always true
- `dmem_ack` outside REQ is ignored.

## Timing
- Reset (asynchronous):
  - state=IDLE, `rdata_q=0`, flags=0
  - `wb_regwrite=0`, `wb_rd=0`, `wb_data=0`, `dmem_req=0`
  - Reset mid-REQ drops `dmem_req` immediately; the access is abandoned.
- Non-memory instruction: 1 cycle in stage. MEM/WB updates on the following edge.
- Memory instruction with ack in cycle k of REQ: stall is high for k+1 cycles, then 1 DONE cycle. Minimum stage occupancy is 3 cycles.
- `dmem_req` rises one cycle after the op arrives. It stays high until the ack edge. Back-to-back memory ops re-enter REQ via IDLE, so each has ≥1 non-req cycle between requests.
- `pcsrc` is high for exactly one cycle per taken branch.

## Test plan
- ADD with regwrite, `alures=0x2A`, `rd=3` → next edge `wb_regwrite=1`, `wb_rd=3`, `wb_data=0x2A`; stall never high.
- LDUR, `alures=0x100`, ack in the 3rd REQ cycle with rdata `0xDEAD` → stall high 4 cycles; `dmem_req` high 3 cycles with addr `0x100` and we=0; then `wb_data=0xDEAD`; 4 bubbles precede it on MEM/WB.
- STUR, `readreg2=0x55` → `dmem_we=1`, `dmem_wdata=0x55`; `wb_regwrite=0`.
- SUBS sets NZCV=0100, next instruction is B.EQ (`rd=0`) with `branchpc=0x40` → `pcsrc=1`, `branchtarget=0x40`. With NZCV=0000 instead, `pcsrc=0`.
- CBNZ with `readreg2=0` gives `pcsrc=0`; CBZ with `readreg2=0` gives `pcsrc=1`.
- Assert `rst` in the 2nd REQ cycle, then ack arrives → `dmem_req`=0 immediately, ack is ignored, all outputs are zero, and the next op starts from IDLE.
